// File: rtl/dest_drain_arbiter_if.sv
// Bundle between the D0/D1 destination FIFOs, the downstream consumer and the drain arbiter.
// The arbiter uses the master view; the surrounding environment uses the slave view.
interface dest_drain_arbiter_if #(
    parameter int unsigned BW    = 6,
    parameter int unsigned CNT_W = 5
);
    logic             D0_empty;
    logic             D1_empty;
    logic [BW-1:0]    D0_data_out;
    logic [BW-1:0]    D1_data_out;
    logic             D0_rd;
    logic             D1_rd;
    logic             out_ready;
    logic             out_valid;
    logic [BW-1:0]    out_data;
    logic             out_dest;
    logic             cnt_clr;
    logic [CNT_W-1:0] D0_count;
    logic [CNT_W-1:0] D1_count;
    logic             busy;

    modport master (
        input  D0_empty, D1_empty, D0_data_out, D1_data_out, out_ready, cnt_clr,
        output D0_rd, D1_rd, out_valid, out_data, out_dest, D0_count, D1_count, busy
    );

    modport slave (
        output D0_empty, D1_empty, D0_data_out, D1_data_out, out_ready, cnt_clr,
        input  D0_rd, D1_rd, out_valid, out_data, out_dest, D0_count, D1_count, busy
    );
endinterface

// File: rtl/dest_drain_arbiter.sv
// Round-robin drain of destination FIFOs D0/D1 onto one valid/ready port,
// with one read in flight at most and saturating per-destination word counters.
module dest_drain_arbiter #(
    parameter int unsigned BW    = 6,
    parameter int unsigned CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    dest_drain_arbiter_if.master bus
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nx;
    logic             last;
    logic             pend_src;
    logic             grant_c;
    logic             rd0_c;
    logic             rd1_c;
    logic             slot_ok_c;
    logic             xfer_c;
    logic             out_valid_q;
    logic [BW-1:0]    out_data_q;
    logic             out_dest_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    assign slot_ok_c = ~out_valid_q | bus.out_ready;
    assign xfer_c    = out_valid_q & bus.out_ready;

    // Grant selection: prefer the source that did not win last time.
    always_comb begin
        state_nx = state;
        grant_c  = last;
        rd0_c    = 1'b0;
        rd1_c    = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && slot_ok_c && !(bus.D0_empty && bus.D1_empty)) begin
                    if (!bus.D0_empty && !bus.D1_empty) begin
                        grant_c = ~last;
                    end else begin
                        grant_c = bus.D0_empty;
                    end
                    rd0_c    = ~grant_c;
                    rd1_c    = grant_c;
                    state_nx = WAIT;
                end
            end
            WAIT: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            pend_src <= 1'b0;
        end else begin
            state <= state_nx;
            if (rd0_c || rd1_c) begin
                last     <= grant_c;
                pend_src <= grant_c;
            end
        end
    end

    // The slot is always free when WAIT captures, so capture takes priority over clearing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= 1'b0;
        end else if (state == WAIT) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pend_src ? bus.D1_data_out : bus.D0_data_out;
            out_dest_q  <= pend_src;
        end else if (xfer_c) begin
            out_valid_q <= 1'b0;
        end
    end

    // Clear wins over a coincident transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (xfer_c) begin
            if (!out_dest_q && cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + CNT_W'(1);
            if (out_dest_q && cnt1_q != CNT_MAX)  cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign bus.D0_rd     = rd0_c;
    assign bus.D1_rd     = rd1_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_dest  = out_dest_q;
    assign bus.D0_count  = cnt0_q;
    assign bus.D1_count  = cnt1_q;
    assign bus.busy      = (state == WAIT) | out_valid_q;
endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Bench for dest_drain_arbiter: FIFO models, a transaction-level reference model
// (words in flight / in the output slot), directed scenarios and a random soak.
module tb_dest_drain_arbiter;
    localparam int unsigned BW    = 6;
    localparam int unsigned CNT_W = 5;
    localparam int          CMAX  = 31;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dest_drain_arbiter_if #(.BW(BW), .CNT_W(CNT_W)) bus();
    dest_drain_arbiter #(.BW(BW), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk;
    int n_fail;
    int cyc;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];

    // Reference model: the word popped last cycle, the word sitting in the output slot, counts.
    bit            m_last;
    bit            m_fly;
    bit            m_fly_src;
    logic [BW-1:0] m_fly_data;
    bit            m_sv;
    logic [BW-1:0] m_sd;
    bit            m_sdest;
    int            m_cnt[2];

    bit            s_rd0, s_rd1, s_ov, s_dest, s_busy;
    logic [BW-1:0] s_data;
    int            s_c0, s_c1;

    logic [BW-1:0] rr_data[4];
    int            rr_dest[4];
    logic [BW-1:0] got_data[$];
    int            got_dest[$];
    int            got_cyc[$];

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void m_reset();
        m_last   = 1'b1;
        m_fly    = 1'b0;
        m_sv     = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endfunction

    task automatic assert_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        m_reset();
    endtask

    // One clock: compare at the falling edge, advance the model, then act as the FIFOs.
    task automatic do_cycle();
        bit ne0, ne1, iss, src, xfer;
        bus.D0_empty = (q0.size() == 0);
        bus.D1_empty = (q1.size() == 0);
        @(negedge clk);
        if (reset) m_reset();
        s_rd0  = bus.D0_rd;
        s_rd1  = bus.D1_rd;
        s_ov   = bus.out_valid;
        s_data = bus.out_data;
        s_dest = bus.out_dest;
        s_busy = bus.busy;
        s_c0   = int'(bus.D0_count);
        s_c1   = int'(bus.D1_count);

        ne0 = (q0.size() != 0);
        ne1 = (q1.size() != 0);
        iss = !reset && !m_fly && (!m_sv || bus.out_ready) && (ne0 || ne1);
        src = (ne0 && ne1) ? !m_last : !ne0;

        chk("d0_rd", int'(s_rd0), int'(iss && !src));
        chk("d1_rd", int'(s_rd1), int'(iss && src));
        chk("rd_while_empty", int'((s_rd0 && !ne0) || (s_rd1 && !ne1)), 0);
        chk("rd_both", int'(s_rd0 && s_rd1), 0);
        chk("out_valid", int'(s_ov), int'(m_sv));
        if (m_sv) begin
            chk("out_data", int'(s_data), int'(m_sd));
            chk("out_dest", int'(s_dest), int'(m_sdest));
        end
        chk("busy", int'(s_busy), int'(m_fly || m_sv));
        chk("d0_count", s_c0, m_cnt[0]);
        chk("d1_count", s_c1, m_cnt[1]);

        if (!reset) begin
            xfer = m_sv && bus.out_ready;
            if (bus.cnt_clr) begin
                m_cnt[0] = 0;
                m_cnt[1] = 0;
            end else if (xfer && m_cnt[m_sdest] < CMAX) begin
                m_cnt[m_sdest]++;
            end
            if (xfer) m_sv = 1'b0;
            if (m_fly) begin
                m_sv    = 1'b1;
                m_sd    = m_fly_data;
                m_sdest = m_fly_src;
                m_fly   = 1'b0;
            end
            if (iss) begin
                m_fly      = 1'b1;
                m_fly_src  = src;
                m_fly_data = src ? q1[0] : q0[0];
                m_last     = src;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (s_rd0 && q0.size() != 0) bus.D0_data_out = q0.pop_front();
        else                         bus.D0_data_out = BW'($urandom);
        if (s_rd1 && q1.size() != 0) bus.D1_data_out = q1.pop_front();
        else                         bus.D1_data_out = BW'($urandom);
    endtask

    initial begin
        int nrd;
        bit have_first;
        logic [BW-1:0] first_data;

        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        bus.D0_empty = 1'b1;
        bus.D1_empty = 1'b1;
        bus.D0_data_out = '0;
        bus.D1_data_out = '0;
        bus.out_ready = 1'b1;
        bus.cnt_clr = 1'b0;
        rr_data[0] = 6'h0A; rr_data[1] = 6'h0C; rr_data[2] = 6'h0B; rr_data[3] = 6'h0D;
        rr_dest[0] = 0;     rr_dest[1] = 1;     rr_dest[2] = 0;     rr_dest[3] = 1;

        // Reset values; no pop while reset is high even with D0 holding a word.
        assert_reset();
        q0.push_back(6'h2A);
        do_cycle();
        chk("reset_d0_rd", int'(s_rd0), 0);
        chk("reset_out_valid", int'(s_ov), 0);
        chk("reset_out_data", int'(s_data), 0);
        chk("reset_out_dest", int'(s_dest), 0);
        chk("reset_counts", s_c0 + s_c1, 0);
        chk("reset_busy", int'(s_busy), 0);
        q0.delete();
        do_cycle();
        reset = 1'b0;
        do_cycle();

        // Single D0 word: rd in cycle 0, visible in cycle 2, counted afterwards.
        q0.push_back(6'h15);
        do_cycle();
        chk("single_rd_c0", int'(s_rd0), 1);
        do_cycle();
        do_cycle();
        chk("single_valid_c2", int'(s_ov), 1);
        chk("single_data_c2", int'(s_data), 'h15);
        chk("single_dest_c2", int'(s_dest), 0);
        do_cycle();
        chk("single_count", s_c0, 1);
        chk("single_busy_after", int'(s_busy), 0);

        // Round robin: A,B in D0 and C,D in D1 come out A C B D, one every 2 cycles.
        assert_reset();
        do_cycle();
        reset = 1'b0;
        q0.push_back(6'h0A); q0.push_back(6'h0B);
        q1.push_back(6'h0C); q1.push_back(6'h0D);
        for (int i = 0; i < 12; i++) begin
            do_cycle();
            if (s_ov && bus.out_ready) begin
                got_data.push_back(s_data);
                got_dest.push_back(int'(s_dest));
                got_cyc.push_back(cyc);
            end
        end
        chk("rr_nwords", got_data.size(), 4);
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            chk("rr_data", int'(got_data[i]), int'(rr_data[i]));
            chk("rr_dest", got_dest[i], rr_dest[i]);
            if (i > 0) chk("rr_gap", got_cyc[i] - got_cyc[i-1], 2);
        end
        chk("rr_d0_count", s_c0, 2);
        chk("rr_d1_count", s_c1, 2);

        // Backpressure: one capture, stable output, no further pops while stalled.
        assert_reset();
        do_cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(BW'(6'h21 + i));
            q1.push_back(BW'(6'h31 + i));
        end
        bus.out_ready = 1'b0;
        nrd = 0;
        have_first = 1'b0;
        first_data = '0;
        for (int i = 0; i < 7; i++) begin
            do_cycle();
            nrd += int'(s_rd0) + int'(s_rd1);
            if (s_ov) begin
                if (!have_first) begin
                    first_data = s_data;
                    have_first = 1'b1;
                end else begin
                    chk("bp_stable", int'(s_data), int'(first_data));
                end
            end
        end
        chk("bp_rd_pulses", nrd, 1);
        chk("bp_held_word", int'(first_data), 'h21);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) do_cycle();

        // Saturation at 31, then a clear coinciding with a transfer.
        assert_reset();
        do_cycle();
        reset = 1'b0;
        for (int i = 0; i < 33; i++) q1.push_back(BW'(i + 1));
        for (int i = 0; i < 72; i++) do_cycle();
        chk("sat_d1_count", s_c1, 31);
        chk("sat_d0_count", s_c0, 0);
        q1.push_back(6'h3F);
        do_cycle();
        do_cycle();
        bus.cnt_clr = 1'b1;
        do_cycle();
        chk("clr_xfer_valid", int'(s_ov), 1);
        bus.cnt_clr = 1'b0;
        do_cycle();
        chk("clr_wins", s_c1, 0);

        // Reset the cycle after D1_rd: the word is dropped; D0 wins first afterwards.
        assert_reset();
        do_cycle();
        reset = 1'b0;
        do_cycle();
        q1.push_back(6'h2C);
        do_cycle();
        chk("mid_d1_rd", int'(s_rd1), 1);
        assert_reset();
        do_cycle();
        chk("mid_no_valid", int'(s_ov), 0);
        chk("mid_d1_count", s_c1, 0);
        do_cycle();
        chk("mid_no_valid2", int'(s_ov), 0);
        reset = 1'b0;
        q0.push_back(6'h05);
        q1.push_back(6'h06);
        do_cycle();
        chk("mid_first_d0", int'(s_rd0), 1);
        for (int i = 0; i < 8; i++) do_cycle();

        // Random soak: random fills, ready, clears and the odd reset.
        for (int i = 0; i < 10000; i++) begin
            if (reset) begin
                if ($urandom_range(0, 3) == 0) reset = 1'b0;
            end else if ($urandom_range(0, 1999) == 0) begin
                assert_reset();
            end
            if (q0.size() < 4 && $urandom_range(0, 2) == 0) q0.push_back(BW'($urandom));
            if (q1.size() < 4 && $urandom_range(0, 2) == 0) q1.push_back(BW'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.cnt_clr   = ($urandom_range(0, 49) == 0);
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
